// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: writeback port, read ports,
// issue/hazard handshake and scoreboard status.
interface regfile_scoreboard_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      Wr_En;
   logic [REG_ADDR_WIDTH-1:0] WrtBck_Addr;
   logic [DATA_WIDTH-1:0]     WrtBck_Data;
   logic [REG_ADDR_WIDTH-1:0] Rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] Rs2_addr;
   logic                      rs1_used;
   logic                      rs2_used;
   logic                      issue_valid;
   logic [REG_ADDR_WIDTH-1:0] Rd_issue;
   logic                      flush;
   logic [DATA_WIDTH-1:0]     Rs1_data;
   logic [DATA_WIDTH-1:0]     Rs2_data;
   logic                      stall_out;
   logic [REG_ADDR_WIDTH:0]   pending_cnt;
   logic                      wb_unexpected;

   modport master (
      output Wr_En, WrtBck_Addr, WrtBck_Data, Rs1_addr, Rs2_addr,
             rs1_used, rs2_used, issue_valid, Rd_issue, flush,
      input  Rs1_data, Rs2_data, stall_out, pending_cnt, wb_unexpected
   );

   modport slave (
      input  Wr_En, WrtBck_Addr, WrtBck_Data, Rs1_addr, Rs2_addr,
             rs1_used, rs2_used, issue_valid, Rd_issue, flush,
      output Rs1_data, Rs2_data, stall_out, pending_cnt, wb_unexpected
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32-entry integer register file with two registered read ports, write-first bypass
// and a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
module regfile_scoreboard #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 2**REG_ADDR_WIDTH
) (
   input logic               clk,
   input logic               reset,
   regfile_scoreboard_if.slave rf
);
   localparam int CNT_W = REG_ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
   logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
   logic                  wb_unexp_q, wb_unexp_d;

   logic       wb_clr;
   logic       haz1, haz2, hazd;
   logic       stall;
   logic       issue_acc;
   logic [CNT_W-1:0] pend_cnt;

   assign wb_clr = rf.Wr_En && (rf.WrtBck_Addr != '0);

   // A writeback landing this cycle resolves the hazard via the read bypass.
   always_comb begin
      haz1      = rf.rs1_used && busy_q[rf.Rs1_addr] &&
                  !(wb_clr && (rf.WrtBck_Addr == rf.Rs1_addr));
      haz2      = rf.rs2_used && busy_q[rf.Rs2_addr] &&
                  !(wb_clr && (rf.WrtBck_Addr == rf.Rs2_addr));
      hazd      = (rf.Rd_issue != '0) && busy_q[rf.Rd_issue] &&
                  !(wb_clr && (rf.WrtBck_Addr == rf.Rd_issue));
      stall     = rf.issue_valid && (haz1 || haz2 || hazd);
      issue_acc = rf.issue_valid && !stall && (rf.Rd_issue != '0);
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_clr) regs_d[rf.WrtBck_Addr] = rf.WrtBck_Data;
      regs_d[0] = '0;

      if (rf.Rs1_addr == '0)                              rs1_data_d = '0;
      else if (wb_clr && (rf.WrtBck_Addr == rf.Rs1_addr)) rs1_data_d = rf.WrtBck_Data;
      else                                                rs1_data_d = regs_q[rf.Rs1_addr];

      if (rf.Rs2_addr == '0)                              rs2_data_d = '0;
      else if (wb_clr && (rf.WrtBck_Addr == rf.Rs2_addr)) rs2_data_d = rf.WrtBck_Data;
      else                                                rs2_data_d = regs_q[rf.Rs2_addr];
   end

   // Set is applied after clear so a new producer on the same index stays in flight.
   always_comb begin
      busy_d = busy_q;
      if (rf.flush) begin
         busy_d = '0;
      end else begin
         if (wb_clr)    busy_d[rf.WrtBck_Addr] = 1'b0;
         if (issue_acc) busy_d[rf.Rd_issue]    = 1'b1;
      end
      busy_d[0] = 1'b0;
      wb_unexp_d = wb_unexp_q || (wb_clr && !busy_q[rf.WrtBck_Addr] && !rf.flush);
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 1; i < NUM_REGS; i++) pend_cnt = pend_cnt + CNT_W'(busy_q[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q     <= '{default: '0};
         busy_q     <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         wb_unexp_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         wb_unexp_q <= wb_unexp_d;
      end
   end

   assign rf.Rs1_data      = rs1_data_q;
   assign rf.Rs2_data      = rs2_data_q;
   assign rf.stall_out     = stall;
   assign rf.pending_cnt   = pend_cnt;
   assign rf.wb_unexpected = wb_unexp_q;
endmodule
